// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the serial ADC capture block.
package adc_pkg;

    localparam int unsigned SCLK_HALF_DIV    = 5;
    localparam int unsigned ADC_FRAME_BITS   = 16;
    localparam int unsigned ADC_DATA_BITS    = 12;
    localparam int unsigned ADC_QUIET_CYCLES = 10;
    localparam int unsigned LEAD_BITS        = ADC_FRAME_BITS - ADC_DATA_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StDone,
        StQuiet
    } adc_state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI clock generator: half-period counter and sclk register, with strobes for the frame FSM.
module adc_sclk_gen #(
    parameter int unsigned HALF_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic toggle,
    output logic sclk,
    output logic half_done,
    output logic sclk_rise
);

    localparam int unsigned CntW = $clog2(HALF_DIV);

    logic [CntW-1:0] cnt;

    assign half_done = en && (cnt == CntW'(HALF_DIV - 1));
    assign sclk_rise = half_done && toggle && !sclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (half_done) begin
            cnt <= '0;
            if (toggle) begin
                sclk <= ~sclk;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_capture.sv
// Runs one SPI read frame on a 12-bit serial ADC per s_clk rising edge and strobes the sample out.
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int unsigned HALF_DIV     = SCLK_HALF_DIV,
    parameter int unsigned FRAME_BITS   = ADC_FRAME_BITS,
    parameter int unsigned DATA_BITS    = ADC_DATA_BITS,
    parameter int unsigned QUIET_CYCLES = ADC_QUIET_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_clk,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 sample_err,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned BitW   = $clog2(FRAME_BITS);
    localparam int unsigned QuietW = $clog2(QUIET_CYCLES) + 1;

    adc_state_e             state;
    logic                   s_prev;
    logic                   start;
    logic [FRAME_BITS-1:0]  shreg;
    logic [BitW-1:0]        bit_cnt;
    logic [QuietW-1:0]      q_cnt;
    logic                   gen_en;
    logic                   gen_toggle;
    logic                   last_high;
    logic                   half_done;
    logic                   sclk_rise;

    assign start      = s_clk & ~s_prev;
    assign gen_en     = (state == StSetup) || (state == StShift);
    // sclk must stay high after the final bit's high phase instead of starting another low phase.
    assign last_high  = (state == StShift) && sclk && (bit_cnt == BitW'(FRAME_BITS - 1));
    assign gen_toggle = !last_high;

    adc_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (gen_en),
        .toggle    (gen_toggle),
        .sclk      (sclk),
        .half_done (half_done),
        .sclk_rise (sclk_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            s_prev       <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            q_cnt        <= '0;
            cs_n         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            sample_err   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            s_prev       <= s_clk;
            if (start && state != StIdle) begin
                overrun <= 1'b1;
            end
            if (sclk_rise) begin
                shreg <= {shreg[FRAME_BITS-2:0], miso};
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StSetup;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                StSetup: begin
                    if (half_done) begin
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (half_done && sclk) begin
                        if (last_high) begin
                            state        <= StDone;
                            cs_n         <= 1'b1;
                            sample       <= shreg[DATA_BITS-1:0];
                            sample_err   <= |shreg[FRAME_BITS-1:DATA_BITS];
                            sample_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    q_cnt <= '0;
                    state <= StQuiet;
                end
                StQuiet: begin
                    if (q_cnt == QuietW'(QUIET_CYCLES - 1)) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        q_cnt <= q_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: default build plus a HALF_DIV=2 build, each with an ADC model.
module tb_adc_spi_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_clk = 1'b0;
    logic        miso = 1'b0;
    logic        cs_n, sclk, sample_valid, sample_err, busy, overrun;
    logic [11:0] sample;

    logic        s_clk2 = 1'b0;
    logic        miso2 = 1'b0;
    logic        cs_n2, sclk2, sample_valid2, sample_err2, busy2, overrun2;
    logic [11:0] sample2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_spi_capture dut (
        .clk          (clk),
        .reset        (reset),
        .s_clk        (s_clk),
        .miso         (miso),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_err   (sample_err),
        .busy         (busy),
        .overrun      (overrun)
    );

    adc_spi_capture #(
        .HALF_DIV (2)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .s_clk        (s_clk2),
        .miso         (miso2),
        .cs_n         (cs_n2),
        .sclk         (sclk2),
        .sample       (sample2),
        .sample_valid (sample_valid2),
        .sample_err   (sample_err2),
        .busy         (busy2),
        .overrun      (overrun2)
    );

    // ADC models: present the next frame bit MSB first after each falling sclk.
    logic [15:0] adc_word = 16'h0;
    logic [15:0] adc_word2 = 16'h0;
    int          bit_idx = 15;
    int          bit_idx2 = 15;

    always @(negedge cs_n) bit_idx = 15;
    always @(negedge sclk) begin
        if (!cs_n && bit_idx >= 0) begin
            miso = adc_word[bit_idx];
            bit_idx--;
        end
    end

    always @(negedge cs_n2) bit_idx2 = 15;
    always @(negedge sclk2) begin
        if (!cs_n2 && bit_idx2 >= 0) begin
            miso2 = adc_word2[bit_idx2];
            bit_idx2--;
        end
    end

    // Monitor, sampled on the falling clk edge.
    int          cyc = 0;
    int          cs_low, cs_falls, busy_cnt, fall_cyc;
    int          sclk_pulses, low_run, low_min, low_max;
    int          valid_cnt, valid_first, valid_last;
    logic        last_err;
    logic [11:0] sample_log [16];
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    int          cs_low2, valid_cnt2;

    task automatic mon_clear();
        cs_low = 0; cs_falls = 0; busy_cnt = 0; fall_cyc = 0;
        sclk_pulses = 0; low_run = 0; low_min = 999; low_max = 0;
        valid_cnt = 0; valid_first = 0; valid_last = 0; last_err = 1'b0;
        cs_low2 = 0; valid_cnt2 = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!cs_n && cs_prev) begin
            cs_falls++;
            fall_cyc = cyc;
        end
        if (!cs_n) cs_low++;
        if (busy) busy_cnt++;
        if (!sclk) begin
            low_run++;
        end else if (!sclk_prev) begin
            sclk_pulses++;
            if (low_run < low_min) low_min = low_run;
            if (low_run > low_max) low_max = low_run;
            low_run = 0;
        end
        if (sample_valid) begin
            if (valid_cnt == 0) valid_first = cyc;
            if (valid_cnt < 16) sample_log[valid_cnt] = sample;
            valid_last = cyc;
            last_err = sample_err;
            valid_cnt++;
        end
        if (!cs_n2) cs_low2++;
        if (sample_valid2) valid_cnt2++;
        cs_prev = cs_n;
        sclk_prev = sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] w);
        adc_word = w;
        mon_clear();
        s_clk = 1'b1;
        cycles(300);
        s_clk = 1'b0;
        cycles(10);
    endtask

    initial begin
        mon_clear();
        #100;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_sample", 32'(sample), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(sample_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cycles(5);

        // Single frame, held-high s_clk must not retrigger.
        run_frame(16'h0A5C);
        check("single_cs_low", 32'(cs_low), 32'd165);
        check("single_cs_falls", 32'(cs_falls), 32'd1);
        check("single_sclk_pulses", 32'(sclk_pulses), 32'd16);
        check("single_low_min", 32'(low_min), 32'd5);
        check("single_low_max", 32'(low_max), 32'd5);
        check("single_valid_cnt", 32'(valid_cnt), 32'd1);
        check("single_latency", 32'(valid_first - fall_cyc), 32'd165);
        check("single_sample", 32'(sample_log[0]), 32'hA5C);
        check("single_err", 32'(last_err), 32'd0);
        check("single_busy", 32'(busy_cnt), 32'd176);
        check("single_hold", 32'(sample), 32'hA5C);

        // Nonzero leading bit flags a format error.
        run_frame(16'h8FFF);
        check("fmt_valid_cnt", 32'(valid_cnt), 32'd1);
        check("fmt_sample", 32'(sample_log[0]), 32'hFFF);
        check("fmt_err", 32'(last_err), 32'd1);

        // Continuous 4536-cycle sample period.
        mon_clear();
        for (int k = 0; k < 10; k++) begin
            adc_word = 16'(k);
            s_clk = 1'b1;
            cycles(2268);
            s_clk = 1'b0;
            cycles(2268);
        end
        check("cont_valid_cnt", 32'(valid_cnt), 32'd10);
        check("cont_span", 32'(valid_last - valid_first), 32'd40824);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("cont_sample%0d", k), 32'(sample_log[k]), 32'(k));
        end
        check("cont_overrun", 32'(overrun), 32'd0);

        // Second rising edge mid-SHIFT.
        adc_word = 16'h0123;
        mon_clear();
        s_clk = 1'b1;
        cycles(20);
        s_clk = 1'b0;
        cycles(30);
        s_clk = 1'b1;
        cycles(300);
        check("ovr_valid_cnt", 32'(valid_cnt), 32'd1);
        check("ovr_cs_falls", 32'(cs_falls), 32'd1);
        check("ovr_sample", 32'(sample_log[0]), 32'h123);
        check("ovr_flag", 32'(overrun), 32'd1);
        s_clk = 1'b0;
        cycles(100);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset 80 cycles into SHIFT.
        adc_word = 16'h0777;
        mon_clear();
        s_clk = 1'b1;
        cycles(86);
        reset = 1'b1;
        #1;
        check("rmid_cs_n", 32'(cs_n), 32'd1);
        check("rmid_sclk", 32'(sclk), 32'd1);
        check("rmid_sample", 32'(sample), 32'h0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_overrun", 32'(overrun), 32'd0);
        s_clk = 1'b0;
        cycles(5);
        reset = 1'b0;
        cycles(200);
        check("rmid_no_valid", 32'(valid_cnt), 32'd0);
        check("rmid_idle_cs_falls", 32'(cs_falls), 32'd1);
        run_frame(16'h0777);
        check("rmid_next_valid", 32'(valid_cnt), 32'd1);
        check("rmid_next_cs_low", 32'(cs_low), 32'd165);
        check("rmid_next_sample", 32'(sample_log[0]), 32'h777);

        // HALF_DIV=2 build.
        adc_word2 = 16'h0A5C;
        mon_clear();
        s_clk2 = 1'b1;
        cycles(150);
        s_clk2 = 1'b0;
        cycles(10);
        check("hd2_cs_low", 32'(cs_low2), 32'd66);
        check("hd2_valid_cnt", 32'(valid_cnt2), 32'd1);
        check("hd2_sample", 32'(sample2), 32'hA5C);
        check("hd2_err", 32'(sample_err2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
